pool_out_collector: RTL and testbench

POOL_OUT_COLLECTOR -- requirements
Module: pool_out_collector

---
 rtl/pool_pkg.sv | 22 ++
 rtl/pool_out_fifo.sv | 69 ++++++
 rtl/pool_out_collector.sv | 132 +++++++++++++
 tb/tb_pool_out_collector.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared definitions for the pooling output stage.
// Holds default geometry/width values and the FIFO entry payload type.
package pool_pkg;

    localparam int unsigned POOL_DATA_W     = 16;
    localparam int unsigned POOL_M          = 6;
    localparam int unsigned POOL_P          = 2;
    localparam int unsigned POOL_FIFO_DEPTH = 4;

    // One buffered output word with its row/frame position tags.
    typedef struct packed {
        logic [POOL_DATA_W-1:0] data;
        logic                   last;
        logic                   frame;
    } pool_entry_t;

    // Index width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/pool_out_fifo.sv
// Synchronous first-word-fall-through FIFO for pooled output words.
// Ports:
//   clk, rst         - rising-edge clock, synchronous active-high reset
//   push, push_data  - write request and entry (ignored when full unless popping)
//   pop              - consume head (ignored when empty)
//   head             - current head entry, valid whenever empty=0
//   full, empty      - occupancy flags
module pool_out_fifo
    import pool_pkg::*;
#(
    parameter int unsigned DEPTH = POOL_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  pool_entry_t push_data,
    input  logic        pop,
    output pool_entry_t head,
    output logic        full,
    output logic        empty
);

    localparam int unsigned AW = clog2_min1(DEPTH);
    localparam int unsigned CW = AW + 1;

    pool_entry_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic do_pop;
    logic do_push;

    assign empty   = (count == CW'(0));
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is allowed when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/pool_out_collector.sv
// Collects pooled values, tags row/frame boundaries and buffers them for a
// ready/valid downstream consumer.
// Optional feature: define POOL_OUT_RELU_EN to clamp negative values to zero.
// Ports:
//   clk, master_rst            - clock, synchronous active-high reset
//   op_en, pool_in, end_op     - upstream value strobe, value, frame end
//   out_ready                  - downstream accept
//   out_valid, out_data        - buffered word (data is 0 when not valid)
//   out_last, out_frame        - row-end / frame-end tags of out_data
//   overflow, short_frame      - sticky error flags
//   frame_cnt                  - frames fully delivered, wraps at 256
module pool_out_collector
    import pool_pkg::*;
#(
    parameter int unsigned DATA_W     = POOL_DATA_W,
    parameter int unsigned M          = POOL_M,
    parameter int unsigned P          = POOL_P,
    parameter int unsigned FIFO_DEPTH = POOL_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              master_rst,
    input  logic              op_en,
    input  logic [DATA_W-1:0] pool_in,
    input  logic              end_op,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              out_frame,
    output logic              overflow,
    output logic              short_frame,
    output logic [7:0]        frame_cnt
);

    localparam int unsigned ROW_LEN = M / P;
    localparam int unsigned IDX_W   = clog2_min1(ROW_LEN);

    logic [IDX_W-1:0] col_idx;
    logic [IDX_W-1:0] row_idx;
    logic [IDX_W-1:0] col_nxt;
    logic [IDX_W-1:0] row_nxt;
    logic             short_set;

    pool_entry_t      wr_entry;
    pool_entry_t      head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             push_ok;
    logic             tag_last;
    logic             tag_frame;
    logic [DATA_W-1:0] store_val;

    // Value conditioning before buffering.
`ifdef POOL_OUT_RELU_EN
    assign store_val = pool_in[DATA_W-1] ? '0 : pool_in;
`else
    assign store_val = pool_in;
`endif

    assign pop       = out_valid && out_ready;
    assign push_ok   = op_en && (!fifo_full || pop) && !master_rst;
    assign tag_last  = (col_idx == IDX_W'(ROW_LEN - 1));
    assign tag_frame = tag_last && (row_idx == IDX_W'(ROW_LEN - 1));

    assign wr_entry.data  = POOL_DATA_W'(store_val);
    assign wr_entry.last  = tag_last;
    assign wr_entry.frame = tag_frame;

    pool_out_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (master_rst),
        .push      (push_ok),
        .push_data (wr_entry),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Head presentation; data/tags forced to zero while nothing is buffered.
    assign out_valid = !fifo_empty;
    assign out_data  = out_valid ? DATA_W'(head.data) : '0;
    assign out_last  = out_valid && head.last;
    assign out_frame = out_valid && head.frame;

    // Next position: advance on push, then abort a partial frame on end_op.
    always_comb begin
        col_nxt   = col_idx;
        row_nxt   = row_idx;
        short_set = 1'b0;
        if (push_ok) begin
            if (tag_last) begin
                col_nxt = '0;
                row_nxt = tag_frame ? '0 : row_idx + IDX_W'(1);
            end else begin
                col_nxt = col_idx + IDX_W'(1);
            end
        end
        if (end_op && ((col_nxt != '0) || (row_nxt != '0))) begin
            short_set = 1'b1;
            col_nxt   = '0;
            row_nxt   = '0;
        end
    end

    // Position, sticky flags and delivered-frame counter.
    always_ff @(posedge clk) begin
        if (master_rst) begin
            col_idx     <= '0;
            row_idx     <= '0;
            overflow    <= 1'b0;
            short_frame <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            col_idx <= col_nxt;
            row_idx <= row_nxt;
            if (op_en && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
            if (short_set) begin
                short_frame <= 1'b1;
            end
            if (pop && head.frame) begin
                frame_cnt <= frame_cnt + 8'(1);
            end
        end
    end

endmodule

// File: tb/tb_pool_out_collector.sv
module tb_pool_out_collector;

    logic        clk = 1'b0;
    logic        master_rst;
    logic        op_en;
    logic [15:0] pool_in;
    logic        end_op;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_frame;
    logic        overflow;
    logic        short_frame;
    logic [7:0]  frame_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pool_out_collector dut (
        .clk         (clk),
        .master_rst  (master_rst),
        .op_en       (op_en),
        .pool_in     (pool_in),
        .end_op      (end_op),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_frame   (out_frame),
        .overflow    (overflow),
        .short_frame (short_frame),
        .frame_cnt   (frame_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        master_rst = 1'b1;
        op_en      = 1'b0;
        end_op     = 1'b0;
        step();
        master_rst = 1'b0;
    endtask

    task automatic test_reset();
        master_rst = 1'b1;
        op_en      = 1'b1;
        pool_in    = 16'h1234;
        end_op     = 1'b0;
        out_ready  = 1'b0;
        step();
        master_rst = 1'b0;
        op_en      = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0 || out_last !== 1'b0 || out_frame !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b data=%h last=%b frame=%b, need 0/0000/0/0",
                     out_valid, out_data, out_last, out_frame);
        end
        checks++;
        if (overflow !== 1'b0 || short_frame !== 1'b0 || frame_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_flags: ovf=%b short=%b cnt=%0d, need 0/0/0", overflow, short_frame, frame_cnt);
        end
    endtask

    task automatic test_full_frame();
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            op_en   = 1'b1;
            pool_in = 16'(i);
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'(i) || out_last !== (i % 3 == 0) || out_frame !== (i == 9)) begin
                errors++;
                $display("FAIL full_frame word %0d: valid=%b data=%0d last=%b frame=%b, need 1/%0d/%b/%b",
                         i, out_valid, out_data, out_last, out_frame, i, (i % 3 == 0), (i == 9));
            end
        end
        op_en = 1'b0;
        step();
        checks++;
        if (frame_cnt !== 8'd1 || out_valid !== 1'b0 || out_data !== 16'h0) begin
            errors++;
            $display("FAIL full_frame_end: cnt=%0d valid=%b data=%h, need 1/0/0000", frame_cnt, out_valid, out_data);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            op_en   = 1'b1;
            pool_in = 16'(i);
            step();
            checks++;
            if (out_data !== 16'd1 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_stable push %0d: valid=%b data=%0d, need 1/1", i, out_valid, out_data);
            end
        end
        op_en = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL bp_overflow: got %b need 1", overflow);
        end
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'(k) || out_last !== (k == 3)) begin
                errors++;
                $display("FAIL bp_drain word %0d: valid=%b data=%0d last=%b, need 1/%0d/%b",
                         k, out_valid, out_data, out_last, k, (k == 3));
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty: valid=%b need 0", out_valid);
        end
        // Four accepted pushes leave the position at col 1, row 1.
        op_en   = 1'b1;
        pool_in = 16'd50;
        step();
        checks++;
        if (out_data !== 16'd50 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL bp_idx_a: data=%0d last=%b, need 50/0", out_data, out_last);
        end
        pool_in = 16'd51;
        step();
        op_en = 1'b0;
        checks++;
        if (out_data !== 16'd51 || out_last !== 1'b1 || out_frame !== 1'b0) begin
            errors++;
            $display("FAIL bp_idx_b: data=%0d last=%b frame=%b, need 51/1/0", out_data, out_last, out_frame);
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL bp_sticky: overflow=%b need 1", overflow);
        end
        step();
    endtask

    task automatic test_full_push_pop();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            op_en   = 1'b1;
            pool_in = 16'(10 + i);
            step();
        end
        out_ready = 1'b1;
        pool_in   = 16'd14;
        step();
        op_en     = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (overflow !== 1'b0 || out_data !== 16'd11) begin
            errors++;
            $display("FAIL fpp_accept: overflow=%b head=%0d, need 0/11", overflow, out_data);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'(11 + k)) begin
                errors++;
                $display("FAIL fpp_drain %0d: valid=%b data=%0d, need 1/%0d", k, out_valid, out_data, 11 + k);
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL fpp_occupancy: valid=%b after 4 pops, need 0", out_valid);
        end
    endtask

    task automatic test_short_frame();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            op_en   = 1'b1;
            pool_in = 16'(20 + i);
            step();
        end
        op_en  = 1'b0;
        end_op = 1'b1;
        step();
        end_op = 1'b0;
        checks++;
        if (short_frame !== 1'b1) begin
            errors++;
            $display("FAIL short_flag: got %b need 1", short_frame);
        end
        for (int i = 1; i <= 9; i++) begin
            op_en   = 1'b1;
            pool_in = 16'(76 + i);
            step();
            checks++;
            if (out_data !== 16'(76 + i) || out_last !== (i % 3 == 0) || out_frame !== (i == 9)) begin
                errors++;
                $display("FAIL short_retag word %0d: data=%0d last=%b frame=%b, need %0d/%b/%b",
                         i, out_data, out_last, out_frame, 76 + i, (i % 3 == 0), (i == 9));
            end
        end
        op_en = 1'b0;
        step();
        checks++;
        if (frame_cnt !== 8'd1) begin
            errors++;
            $display("FAIL short_cnt: frame_cnt=%0d need 1", frame_cnt);
        end
    endtask

    task automatic test_reset_mid();
        // Carries frame_cnt=1 and short_frame=1 in from the previous test.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            op_en   = 1'b1;
            pool_in = 16'(30 + i);
            step();
        end
        op_en     = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        out_ready  = 1'b0;
        master_rst = 1'b1;
        op_en      = 1'b1;
        pool_in    = 16'd99;
        step();
        master_rst = 1'b0;
        op_en      = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0 || frame_cnt !== 8'd0 || short_frame !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: valid=%b data=%h cnt=%0d short=%b, need 0/0000/0/0",
                     out_valid, out_data, frame_cnt, short_frame);
        end
        out_ready = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            op_en   = 1'b1;
            pool_in = 16'(40 + i);
            step();
            checks++;
            if (out_data !== 16'(40 + i) || out_last !== (i % 3 == 0) || out_frame !== (i == 9)) begin
                errors++;
                $display("FAIL rst_mid_tag word %0d: data=%0d last=%b frame=%b, need %0d/%b/%b",
                         i, out_data, out_last, out_frame, 40 + i, (i % 3 == 0), (i == 9));
            end
        end
        op_en = 1'b0;
        step();
        checks++;
        if (frame_cnt !== 8'd1) begin
            errors++;
            $display("FAIL rst_mid_cnt: frame_cnt=%0d need 1", frame_cnt);
        end
    endtask

    task automatic test_relu();
        logic [15:0] exp_neg;
`ifdef POOL_OUT_RELU_EN
        exp_neg = 16'h0000;
`else
        exp_neg = 16'hFFFB;
`endif
        do_reset();
        out_ready = 1'b0;
        op_en     = 1'b1;
        pool_in   = 16'hFFFB;
        step();
        op_en = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_neg) begin
            errors++;
            $display("FAIL relu_neg: valid=%b data=%h, need 1/%h", out_valid, out_data, exp_neg);
        end
        out_ready = 1'b1;
        op_en     = 1'b1;
        pool_in   = 16'd7;
        step();
        op_en = 1'b0;
        checks++;
        if (out_data !== 16'd7) begin
            errors++;
            $display("FAIL relu_pos: data=%h need 0007", out_data);
        end
        step();
    endtask

    initial begin
        master_rst = 1'b0;
        op_en      = 1'b0;
        pool_in    = '0;
        end_op     = 1'b0;
        out_ready  = 1'b0;
        #2;
        test_reset();
        test_full_frame();
        test_backpressure();
        test_full_push_pop();
        test_short_frame();
        test_reset_mid();
        test_relu();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
